// File: rtl/des_pkg.sv
// Shared definitions for the DES S-box substitution engine: the FIPS 46-3
// S1..S8 tables, the control-state encoding and the chunk/nibble bit mapping.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_DONE
  } state_e;

  // Box 0 (S1) is leftmost; within a box, entry row*16+col, col 0 leftmost.
  localparam logic [0:7][0:63][3:0] SBOX = {
    // S1
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
    64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    // S2
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
    64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    // S3
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1,
    64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    // S4
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
    64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    // S5
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
    64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    // S6
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
    64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    // S7
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
    64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    // S8
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
    64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  // Table index for a 6-bit chunk: row = {b5,b0}, col = b4..b1.
  function automatic logic [5:0] sbox_index(input logic [5:0] chunk);
    return {chunk[5], chunk[0], chunk[4:1]};
  endfunction

  // LSB position of box n's 6-bit input chunk within the 48-bit word.
  function automatic int unsigned chunk_lsb(input logic [2:0] box);
    return 32'd42 - 32'd6 * 32'(box);
  endfunction

  // LSB position of box n's 4-bit output nibble within the 32-bit result.
  function automatic int unsigned nibble_lsb(input logic [2:0] box);
    return 32'd28 - 32'd4 * 32'(box);
  endfunction

endpackage

// File: rtl/des_sbox.sv
// Single combinational DES S-box: selects one of S1..S8 by index and maps a
// 6-bit chunk to its 4-bit substitution nibble.
module des_sbox
  import des_pkg::*;
(
  input  logic [2:0] box_i,
  input  logic [5:0] chunk_i,
  output logic [3:0] nibble_o
);

  assign nibble_o = SBOX[box_i][sbox_index(chunk_i)];

endmodule

// File: rtl/des_sbox_engine.sv
// Sequential DES S-box engine: captures a 48-bit word, evaluates LANES S-boxes
// per cycle over STEPS cycles, and presents the 32-bit result on a valid/ready port.
module des_sbox_engine
  import des_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic        busy
);

  localparam int STEPS  = 8 / LANES;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  state_e              state_q;
  logic [47:0]         data_q;
  logic [STEP_W-1:0]   step_q;
  logic [31:0]         result_q;
  logic [31:0]         result_d;
  logic [31:0]         dout_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [2:0]          lane_box   [LANES];
  logic [5:0]          lane_chunk [LANES];
  logic [3:0]          lane_nib   [LANES];

  // Lane l of step s handles box s*LANES+l, so boxes are covered in order S1..S8.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_box[l]   = 3'(int'(step_q) * LANES + l);
    assign lane_chunk[l] = data_q[chunk_lsb(lane_box[l]) +: 6];

    des_sbox u_sbox (
      .box_i    (lane_box[l]),
      .chunk_i  (lane_chunk[l]),
      .nibble_o (lane_nib[l])
    );
  end

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first; a
    // path that leaves it unassigned would infer a latch.
    result_d = result_q;
    for (int l = 0; l < LANES; l++) begin
      result_d[nibble_lsb(lane_box[l]) +: 4] = lane_nib[l];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      step_q      <= '0;
      result_q    <= '0;
      dout_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_q     <= data_in;
            step_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_SUB;
          end
        end

        ST_SUB: begin
          result_q <= result_d;
          if (step_q == STEP_W'(STEPS - 1)) begin
            // The last lanes land directly in dout so it is complete on entry to DONE.
            dout_q      <= result_d;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign dout      = dout_q;

endmodule
